// File: rtl/conv_mac_seq.sv
// conv_mac_seq: sequential KSIZE x KSIZE dot-product engine built around one half-width multiplier.
// Optional macro CONV_SAT_EN saturates result to all ones on overflow (default: wrap modulo 2^NBITS).
module conv_mac_seq #(
  parameter int unsigned NBITS = 20,
  parameter int unsigned KSIZE = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] pixel,
  input  logic [NBITS-1:0] weight,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] result,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned H    = NBITS / 2;
  localparam int unsigned N    = KSIZE * KSIZE;
  localparam int unsigned ACCW = 2 * NBITS + 5;
  localparam int unsigned CW   = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_OUT} state_t;
  typedef enum logic [1:0] {PH_ALBL, PH_ALBH, PH_AHBL, PH_AHBH} phase_t;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [CW-1:0]    count_q, count_d;
  logic [NBITS-1:0] a_q, a_d, b_q, b_d;
  logic [ACCW-1:0]  acc_q, acc_d;
  logic             out_valid_d, ovf_d, busy_d;
  logic [NBITS-1:0] result_d;

  logic [H-1:0]     mul_a, mul_b;
  logic [NBITS-1:0] prod;
  logic [ACCW-1:0]  addend, acc_sum;
  logic [NBITS-1:0] res_sum;
  logic             ovf_sum, last_pair;

  // Half-operand selection for the current phase
  always_comb begin
    mul_a = a_q[H-1:0];
    mul_b = b_q[H-1:0];
    case (phase_q)
      PH_ALBH: mul_b = b_q[NBITS-1:H];
      PH_AHBL: mul_a = a_q[NBITS-1:H];
      PH_AHBH: begin
        mul_a = a_q[NBITS-1:H];
        mul_b = b_q[NBITS-1:H];
      end
      default: ;
    endcase
  end

  assign prod = NBITS'(mul_a) * NBITS'(mul_b);

  // Align the partial product to its weight in the full product
  always_comb begin
    case (phase_q)
      PH_ALBL: addend = ACCW'(prod);
      PH_AHBH: addend = ACCW'(prod) << NBITS;
      default: addend = ACCW'(prod) << H;
    endcase
  end

  assign acc_sum   = acc_q + addend;
  assign ovf_sum   = |acc_sum[ACCW-1:NBITS];
  assign last_pair = (count_q == CW'(N - 1));

`ifdef CONV_SAT_EN
  assign res_sum = ovf_sum ? {NBITS{1'b1}} : acc_sum[NBITS-1:0];
`else
  assign res_sum = acc_sum[NBITS-1:0];
`endif

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    count_d     = count_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    out_valid_d = out_valid;
    result_d    = result;
    ovf_d       = ovf;
    busy_d      = busy;
    in_ready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = !clear;
        if (in_valid && !clear) begin
          a_d     = pixel;
          b_d     = weight;
          phase_d = PH_ALBL;
          state_d = S_MUL;
          busy_d  = 1'b1;
        end
      end
      S_MUL: begin
        acc_d = acc_sum;
        case (phase_q)
          PH_ALBL: phase_d = PH_ALBH;
          PH_ALBH: phase_d = PH_AHBL;
          PH_AHBL: phase_d = PH_AHBH;
          default: begin
            if (last_pair) begin
              state_d     = S_OUT;
              out_valid_d = 1'b1;
              result_d    = res_sum;
              ovf_d       = ovf_sum;
            end else begin
              in_ready = !clear;
              count_d  = count_q + CW'(1);
              phase_d  = PH_ALBL;
              if (in_valid && !clear) begin
                a_d = pixel;
                b_d = weight;
              end else begin
                state_d = S_IDLE;
              end
            end
          end
        endcase
      end
      S_OUT: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          acc_d       = '0;
          count_d     = '0;
          out_valid_d = 1'b0;
          result_d    = '0;
          ovf_d       = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort: discard any in-flight pair or pending result
    if (clear) begin
      state_d     = S_IDLE;
      phase_d     = PH_ALBL;
      count_d     = '0;
      acc_d       = '0;
      out_valid_d = 1'b0;
      result_d    = '0;
      ovf_d       = 1'b0;
      busy_d      = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      phase_q   <= PH_ALBL;
      count_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      count_q   <= count_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      out_valid <= out_valid_d;
      result    <= result_d;
      ovf       <= ovf_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_conv_mac_seq.sv
// Self-checking bench for conv_mac_seq: one 3x3 and one 5x5 instance, table vectors,
// hand sequences for clear/reset/stall corners, and random windows against a sum-of-products model.
module tb_conv_mac_seq;

  localparam int unsigned NB = 20;

  logic          clock, reset;
  logic          clear     [2];
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [NB-1:0] pixel     [2];
  logic [NB-1:0] weight    [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [NB-1:0] result    [2];
  logic          ovf       [2];
  logic          busy      [2];

  conv_mac_seq #(.NBITS(NB), .KSIZE(3)) dut3 (
    .clock(clock), .reset(reset), .clear(clear[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .pixel(pixel[0]), .weight(weight[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result(result[0]), .ovf(ovf[0]), .busy(busy[0])
  );

  conv_mac_seq #(.NBITS(NB), .KSIZE(5)) dut5 (
    .clock(clock), .reset(reset), .clear(clear[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .pixel(pixel[1]), .weight(weight[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result(result[1]), .ovf(ovf[1]), .busy(busy[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc;
  always @(posedge clock) cyc <= cyc + 1;

  int nvec, nerr;
  logic [NB-1:0] pv [25];
  logic [NB-1:0] wv [25];

  typedef struct {
    int            k;
    logic [NB-1:0] p0, w0, p, w;
    logic [NB-1:0] r;
    logic          o;
  } vec_t;
  vec_t tab [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: true dot product, then wrap or saturate to NB bits
  function automatic logic [NB:0] model(input longint unsigned s);
    logic          o;
    logic [NB-1:0] r;
    o = (s >= (64'd1 << NB));
    r = s[NB-1:0];
`ifdef CONV_SAT_EN
    if (o) r = '1;
`endif
    return {o, r};
  endfunction

  function automatic logic [NB-1:0] rnd_val();
    case ($urandom_range(0, 2))
      0:       return NB'($urandom_range(0, 15));
      1:       return NB'($urandom);
      default: return NB'($urandom_range(0, 1023));
    endcase
  endfunction

  // Called just after a posedge; returns just after the accepting posedge
  task automatic send_pair(input int k, input logic [NB-1:0] p, input logic [NB-1:0] w,
                           input int gap, output int c);
    bit done;
    done = 0;
    c = -1;
    in_valid[k] = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
    pixel[k] = p;
    weight[k] = w;
    in_valid[k] = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clock);
      if (in_ready[k]) begin
        c = cyc;
        done = 1;
      end
      @(posedge clock); #1;
    end
    in_valid[k] = 1'b0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic get_result(input int k, input int stall, output logic [NB-1:0] r,
                            output logic o, output int vc);
    bit seen;
    int bad;
    seen = 0;
    bad = 0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clock);
      if (out_valid[k]) seen = 1;
    end
    chk("out_valid_timeout", 64'(seen), 1);
    if (!seen) begin
      r = 'x; o = 1'bx; vc = -1;
      @(posedge clock); #1;
      return;
    end
    vc = cyc;
    r = result[k];
    o = ovf[k];
    chk("busy_in_out", 64'(busy[k]), 1);
    in_valid[k] = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(posedge clock);
      @(negedge clock);
      if (in_ready[k] !== 1'b0 || out_valid[k] !== 1'b1 || result[k] !== r || ovf[k] !== o) bad++;
    end
    if (stall > 0) chk("stall_hold", 64'(bad), 0);
    out_ready[k] = 1'b1;
    @(posedge clock); #1;
    out_ready[k] = 1'b0;
    in_valid[k] = 1'b0;
    chk("out_valid_drop", 64'(out_valid[k]), 0);
    chk("busy_drop", 64'(busy[k]), 0);
  endtask

  // Sends pv/wv as one window; gap>0 inserts idle cycles before each later pair
  task automatic run_window(input int k, input int gap, input int stall,
                            output logic [NB-1:0] r, output logic o, output int lat,
                            output longint unsigned sum);
    int n, first, c, vc, spacing_err;
    n = (k == 0) ? 9 : 25;
    sum = 0;
    first = 0;
    spacing_err = 0;
    for (int i = 0; i < n; i++) begin
      sum += 64'(pv[i]) * 64'(wv[i]);
      send_pair(k, pv[i], wv[i], (i == 0) ? 0 : gap, c);
      if (i == 0) first = c;
      else if (gap == 0 && c != first + 4 * i) spacing_err++;
    end
    if (gap == 0) chk("accept_spacing", 64'(spacing_err), 0);
    get_result(k, stall, r, o, vc);
    lat = vc - first;
  endtask

  task automatic fill(input logic [NB-1:0] p0, input logic [NB-1:0] w0,
                      input logic [NB-1:0] p, input logic [NB-1:0] w);
    for (int i = 0; i < 25; i++) begin
      pv[i] = (i == 0) ? p0 : p;
      wv[i] = (i == 0) ? w0 : w;
    end
  endtask

  task automatic chk_reset_vals(input int k, input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready[k]), 1);
    chk({tag, "_out_valid"}, 64'(out_valid[k]), 0);
    chk({tag, "_result"}, 64'(result[k]), 0);
    chk({tag, "_ovf"}, 64'(ovf[k]), 0);
    chk({tag, "_busy"}, 64'(busy[k]), 0);
  endtask

  initial begin
    logic [NB-1:0]   r, er;
    logic            o;
    logic [NB:0]     m;
    int              lat, c, n, gap, k;
    bit              seen;
    longint unsigned sum;

    nvec = 0;
    nerr = 0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      clear[i] = 1'b0; in_valid[i] = 1'b0; out_ready[i] = 1'b0;
      pixel[i] = '0; weight[i] = '0;
    end

    tab[0] = '{0, 20'h00001, 20'h00001, 20'h00001, 20'h00001, 20'h00009, 1'b0};
    tab[1] = '{0, 20'h003FF, 20'h00401, 20'h00000, 20'h00000, 20'hFFFFF, 1'b0};
    tab[2] = '{0, 20'h00400, 20'h00400, 20'h00000, 20'h00000, 20'h00000, 1'b1};
    tab[3] = '{0, 20'hFFFFF, 20'h00001, 20'hFFFFF, 20'h00001, 20'hFFFF7, 1'b1};
    tab[4] = '{0, 20'h00002, 20'h00003, 20'h00002, 20'h00003, 20'd54,    1'b0};
    tab[5] = '{1, 20'h00001, 20'h00002, 20'h00001, 20'h00002, 20'd50,    1'b0};

    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk_reset_vals(0, "rst3");
    chk_reset_vals(1, "rst5");
    @(posedge clock); #1;

    // Table vectors, back-to-back
    for (int i = 0; i < 6; i++) begin
      fill(tab[i].p0, tab[i].w0, tab[i].p, tab[i].w);
      run_window(tab[i].k, 0, 0, r, o, lat, sum);
      er = tab[i].r;
`ifdef CONV_SAT_EN
      if (tab[i].o) er = '1;
`endif
      n = (tab[i].k == 0) ? 9 : 25;
      chk($sformatf("vec%0d_result", i), 64'(r), 64'(er));
      chk($sformatf("vec%0d_ovf", i), 64'(o), 64'(tab[i].o));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(4 * n + 1));
    end

    // Idle gaps between pairs and a long stall in OUT with in_valid held high
    for (int i = 0; i < 25; i++) begin pv[i] = rnd_val(); wv[i] = rnd_val(); end
    run_window(0, 7, 10, r, o, lat, sum);
    m = model(sum);
    chk("gap_stall_result", 64'(r), 64'(m[NB-1:0]));
    chk("gap_stall_ovf", 64'(o), 64'(m[NB]));

    // clear while the result is pending drops it
    fill(1, 1, 1, 1);
    for (int i = 0; i < 9; i++) send_pair(0, pv[i], wv[i], 0, c);
    seen = 0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clock);
      if (out_valid[0]) seen = 1;
    end
    chk("clr_out_seen", 64'(seen), 1);
    clear[0] = 1'b1;
    @(posedge clock); #1;
    clear[0] = 1'b0;
    chk("clr_out_valid", 64'(out_valid[0]), 0);
    chk("clr_out_busy", 64'(busy[0]), 0);

    // clear at the AHBH of pair 3 with a pair offered in the same cycle
    fill(7, 9, 7, 9);
    for (int i = 0; i < 4; i++) send_pair(0, pv[i], wv[i], 0, c);
    repeat (3) @(posedge clock);
    #1;
    pixel[0] = 20'd100; weight[0] = 20'd100;
    in_valid[0] = 1'b1;
    clear[0] = 1'b1;
    @(negedge clock);
    chk("clr_in_ready", 64'(in_ready[0]), 0);
    @(posedge clock); #1;
    clear[0] = 1'b0;
    in_valid[0] = 1'b0;
    chk("clr_busy", 64'(busy[0]), 0);
    fill(2, 3, 2, 3);
    run_window(0, 0, 0, r, o, lat, sum);
    chk("after_clr_result", 64'(r), 54);
    chk("after_clr_ovf", 64'(o), 0);

    // Asynchronous reset in the middle of a 5x5 window
    fill(1, 2, 1, 2);
    for (int i = 0; i < 12; i++) send_pair(1, pv[i], wv[i], 0, c);
    chk("pre_rst_busy", 64'(busy[1]), 1);
    reset = 1'b1;
    #1;
    chk_reset_vals(1, "midrst");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    run_window(1, 0, 0, r, o, lat, sum);
    chk("post_rst_result", 64'(r), 50);
    chk("post_rst_latency", 64'(lat), 101);

    // Random windows against the sum-of-products model
    for (int w = 0; w < 10; w++) begin
      k = (w < 8) ? 0 : 1;
      gap = ($urandom_range(0, 2) == 0) ? 7 : 0;
      for (int i = 0; i < 25; i++) begin pv[i] = rnd_val(); wv[i] = rnd_val(); end
      run_window(k, gap, $urandom_range(0, 3), r, o, lat, sum);
      m = model(sum);
      chk($sformatf("rnd%0d_result", w), 64'(r), 64'(m[NB-1:0]));
      chk($sformatf("rnd%0d_ovf", w), 64'(o), 64'(m[NB]));
      if (gap == 0) chk($sformatf("rnd%0d_latency", w), 64'(lat), 64'((k == 0) ? 37 : 101));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
